// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO behind the 8-bit UART Rx: buffers characters with their error flags and produces 16550-style RX status.
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     brcx16,
  input  logic [7:0]               rx_d,
  input  logic                     rx_d_rdy,
  input  logic                     rx_parity_er,
  input  logic                     rx_frame_er,
  input  logic                     rx_break_itr,
  input  logic                     fifo_en,
  input  logic                     fifo_clr,
  input  logic [1:0]               rx_trig,
  input  logic                     rd,
  input  logic                     ovr_clr,
  output logic [7:0]               rd_data,
  output logic                     rd_pe,
  output logic                     rd_fe,
  output logic                     rd_bi,
  output logic                     data_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     trig_hit,
  output logic                     overrun,
  output logic                     err_in_fifo,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt, err_cnt, err_nxt, thr;
  logic          d_rdy_q, fifo_en_q;

  logic          wr, clr, empty, full, do_pop, accept, do_push, do_ovw, ovr_set;
  logic          new_err, head_err, err_inc, err_dec;
  logic [10:0]   head, entry;

  assign wr       = rx_d_rdy & ~d_rdy_q;
  assign clr      = fifo_clr | (fifo_en ^ fifo_en_q);
  assign empty    = (cnt == '0);
  assign full     = fifo_en ? (cnt == CW'(DEPTH)) : (cnt == CW'(1));
  assign do_pop   = rd & ~empty & ~clr;
  assign accept   = wr & ~clr;
  assign do_push  = accept & (~full | do_pop);
  // Holding-register mode replaces the head in place instead of dropping the new character.
  assign do_ovw   = accept & full & ~do_pop & ~fifo_en;
  assign ovr_set  = accept & full & ~do_pop;
  assign new_err  = rx_parity_er | rx_frame_er | rx_break_itr;
  assign entry    = {rx_break_itr, rx_frame_er, rx_parity_er, rx_d};
  assign head     = mem[rd_ptr];
  assign head_err = |head[10:8];
  assign err_inc  = (do_push | do_ovw) & new_err;
  assign err_dec  = (do_pop | do_ovw) & head_err;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (do_push && !do_pop)
      cnt_nxt = cnt + CW'(1);
    else if (do_pop && !do_push)
      cnt_nxt = cnt - CW'(1);
  end

  always_comb begin
    err_nxt = err_cnt;
    if (clr)
      err_nxt = '0;
    else if (err_inc && !err_dec)
      err_nxt = err_cnt + CW'(1);
    else if (err_dec && !err_inc)
      err_nxt = err_cnt - CW'(1);
  end

  always_comb begin
    case (rx_trig)
      2'd0:    thr = CW'(1);
      2'd1:    thr = CW'(DEPTH / 4);
      2'd2:    thr = CW'(DEPTH / 2);
      default: thr = CW'(DEPTH - 2);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (do_push)
        mem[wr_ptr] <= entry;
      else if (do_ovw)
        mem[rd_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      err_cnt   <= '0;
      d_rdy_q   <= 1'b0;
      fifo_en_q <= 1'b0;
      overrun   <= 1'b0;
      trig_hit  <= 1'b0;
    end else begin
      d_rdy_q   <= rx_d_rdy;
      fifo_en_q <= fifo_en;
      cnt       <= cnt_nxt;
      err_cnt   <= err_nxt;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (ovr_set)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
      // Registered against the next count so the trigger level carries no input-to-output path.
      trig_hit <= fifo_en ? (cnt_nxt >= thr) : (cnt_nxt != '0);
    end
  end

  assign count       = cnt;
  assign data_rdy    = ~empty;
  assign err_in_fifo = (err_cnt != '0);
  assign rd_data     = empty ? 8'h00 : head[7:0];
  assign rd_pe       = ~empty & head[8];
  assign rd_fe       = ~empty & head[9];
  assign rd_bi       = ~empty & head[10];

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer   <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr || wr || rd || empty || !fifo_en)
        timer <= '0;
      else if (brcx16 && timer != TW'(TIMEOUT_TICKS))
        timer <= timer + TW'(1);
      if (clr || wr || rd || !fifo_en)
        timeout <= 1'b0;
      else if (timer == TW'(TIMEOUT_TICKS))
        timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_in;
  assign unused_timeout_in = brcx16 & (TIMEOUT_TICKS != 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: table of single-step vectors plus hand-written corner sequences.
module tb_uart_rx_fifo_ctrl;
  logic       clk = 1'b0, rst = 1'b0, brcx16 = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic       rx_d_rdy = 1'b0, rx_parity_er = 1'b0, rx_frame_er = 1'b0, rx_break_itr = 1'b0;
  logic       fifo_en = 1'b1, fifo_clr = 1'b0, rd = 1'b0, ovr_clr = 1'b0;
  logic [1:0] rx_trig = 2'd0;
  logic [7:0] rd_data;
  logic       rd_pe, rd_fe, rd_bi, data_rdy, trig_hit, overrun, err_in_fifo, timeout;
  logic [4:0] count;

  int total = 0, bad = 0;

  uart_rx_fifo_ctrl #(.DEPTH(16), .TIMEOUT_TICKS(640)) dut (
    .clk(clk), .rst(rst), .brcx16(brcx16), .rx_d(rx_d), .rx_d_rdy(rx_d_rdy),
    .rx_parity_er(rx_parity_er), .rx_frame_er(rx_frame_er), .rx_break_itr(rx_break_itr),
    .fifo_en(fifo_en), .fifo_clr(fifo_clr), .rx_trig(rx_trig), .rd(rd), .ovr_clr(ovr_clr),
    .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe), .rd_bi(rd_bi), .data_rdy(data_rdy),
    .count(count), .trig_hit(trig_hit), .overrun(overrun), .err_in_fifo(err_in_fifo),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic [2:0] fl;
    logic       r;
    int         cnt;
    logic [7:0] hd;
    logic [2:0] hfl;
    logic       err;
    logic       trig;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One character (optionally with a pop in the same cycle), then one idle cycle.
  task automatic apply(input logic w, input logic [7:0] d, input logic [2:0] fl, input logic r);
    rx_d = d;
    {rx_break_itr, rx_frame_er, rx_parity_er} = fl;
    rx_d_rdy = w;
    rd = r;
    tick();
    rx_d_rdy = 1'b0;
    rd = 1'b0;
    {rx_break_itr, rx_frame_er, rx_parity_er} = 3'b000;
    tick();
  endtask

  task automatic pulse_clr();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic pulse_ovr_clr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h41, 3'b000, 1'b0, 1, 8'h41, 3'b000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 8'h42, 3'b000, 1'b0, 2, 8'h41, 3'b000, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'h43, 3'b000, 1'b0, 3, 8'h41, 3'b000, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 3'b000, 1'b1, 2, 8'h42, 3'b000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1, 8'h43, 3'b000, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 8'h00, 3'b000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 8'h00, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h20, 3'b000, 1'b0, 1, 8'h20, 3'b000, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h10, 3'b010, 1'b0, 2, 8'h20, 3'b000, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'h30, 3'b000, 1'b0, 3, 8'h20, 3'b000, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 3'b000, 1'b1, 2, 8'h10, 3'b010, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 3'b000, 1'b1, 1, 8'h30, 3'b000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h77, 3'b001, 1'b1, 1, 8'h77, 3'b001, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 8'h00, 3'b000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h66, 3'b100, 1'b1, 1, 8'h66, 3'b100, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 3'b000, 1'b1, 0, 8'h00, 3'b000, 1'b0, 1'b0};

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst count", int'(count), 0);
    check("rst data_rdy", int'(data_rdy), 0);
    check("rst rd_data", int'(rd_data), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst trig_hit", int'(trig_hit), 0);
    check("rst err", int'(err_in_fifo), 0);
    check("rst timeout", int'(timeout), 0);
    rst = 1'b1;
    repeat (3) tick();

    // Basic push/pop, empty pop, error tracking, simultaneous rd/wr
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].w, tbl[i].d, tbl[i].fl, tbl[i].r);
      check($sformatf("v%0d count", i), int'(count), tbl[i].cnt);
      check($sformatf("v%0d rd_data", i), int'(rd_data), int'(tbl[i].hd));
      check($sformatf("v%0d flags", i), int'({rd_bi, rd_fe, rd_pe}), int'(tbl[i].hfl));
      check($sformatf("v%0d data_rdy", i), int'(data_rdy), int'(tbl[i].cnt != 0));
      check($sformatf("v%0d err", i), int'(err_in_fifo), int'(tbl[i].err));
      check($sformatf("v%0d trig", i), int'(trig_hit), int'(tbl[i].trig));
      check($sformatf("v%0d overrun", i), int'(overrun), 0);
    end

    // Fill to 16 at trigger DEPTH/2, then overflow with 0x99
    rx_trig = 2'd2;
    tick();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 8'h80 + 8'(i), 3'b000, 1'b0);
      check($sformatf("fill%0d trig", i), int'(trig_hit), int'(i >= 7));
    end
    check("full count", int'(count), 16);
    check("full overrun", int'(overrun), 0);
    apply(1'b1, 8'h99, 3'b000, 1'b0);
    check("ovf count", int'(count), 16);
    check("ovf overrun", int'(overrun), 1);
    check("ovf head", int'(rd_data), 8'h80);
    pulse_ovr_clr();
    check("ovr_clr", int'(overrun), 0);

    // Full: pop and push 0x55 together
    apply(1'b1, 8'h55, 3'b000, 1'b1);
    check("rdwr full count", int'(count), 16);
    check("rdwr full overrun", int'(overrun), 0);
    check("rdwr full head", int'(rd_data), 8'h81);

    // Overflow coinciding with ovr_clr keeps overrun set
    rx_d = 8'h99;
    rx_d_rdy = 1'b1;
    ovr_clr = 1'b1;
    tick();
    rx_d_rdy = 1'b0;
    ovr_clr = 1'b0;
    tick();
    check("ovr_clr+ovf", int'(overrun), 1);
    pulse_ovr_clr();
    check("ovr_clr again", int'(overrun), 0);

    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), int'(rd_data), (i < 15) ? (8'h81 + i) : 8'h55);
      apply(1'b0, 8'h00, 3'b000, 1'b1);
    end
    check("drained count", int'(count), 0);
    check("drained trig", int'(trig_hit), 0);

    // Holding-register mode
    rx_trig = 2'd3;
    fifo_en = 1'b0;
    repeat (2) tick();
    apply(1'b1, 8'h01, 3'b000, 1'b0);
    check("nf count1", int'(count), 1);
    check("nf data1", int'(rd_data), 8'h01);
    check("nf trig", int'(trig_hit), 1);
    check("nf ovr1", int'(overrun), 0);
    apply(1'b1, 8'h02, 3'b010, 1'b0);
    check("nf data2", int'(rd_data), 8'h02);
    check("nf count2", int'(count), 1);
    check("nf ovr2", int'(overrun), 1);
    check("nf err2", int'(err_in_fifo), 1);
    apply(1'b1, 8'h03, 3'b000, 1'b0);
    check("nf data3", int'(rd_data), 8'h03);
    check("nf err3", int'(err_in_fifo), 0);
    pulse_clr();
    check("clr count", int'(count), 0);
    check("clr keeps ovr", int'(overrun), 1);
    apply(1'b1, 8'h04, 3'b001, 1'b0);
    check("nf count4", int'(count), 1);
    fifo_en = 1'b1;
    tick();
    check("mode chg count", int'(count), 0);
    check("mode chg data", int'(rd_data), 0);
    check("mode chg err", int'(err_in_fifo), 0);
    tick();

`ifdef UART_RX_TIMEOUT_EN
    apply(1'b1, 8'h5A, 3'b000, 1'b0);
    brcx16 = 1'b1;
    repeat (639) tick();
    check("timeout early", int'(timeout), 0);
    tick();
    tick();
    brcx16 = 1'b0;
    check("timeout set", int'(timeout), 1);
    apply(1'b0, 8'h00, 3'b000, 1'b1);
    check("timeout cleared", int'(timeout), 0);
`else
    apply(1'b1, 8'h5A, 3'b000, 1'b0);
    brcx16 = 1'b1;
    repeat (700) tick();
    brcx16 = 1'b0;
    check("timeout tied", int'(timeout), 0);
    apply(1'b0, 8'h00, 3'b000, 1'b1);
`endif

    // Reset mid-operation
    apply(1'b1, 8'hA1, 3'b100, 1'b0);
    apply(1'b1, 8'hA2, 3'b000, 1'b0);
    rst = 1'b0;
    tick();
    check("mid rst count", int'(count), 0);
    check("mid rst data", int'(rd_data), 0);
    check("mid rst flags", int'({rd_bi, rd_fe, rd_pe}), 0);
    check("mid rst ovr", int'(overrun), 1'b0);
    check("mid rst err", int'(err_in_fifo), 0);
    check("mid rst trig", int'(trig_hit), 0);
    check("mid rst rdy", int'(data_rdy), 0);
    check("mid rst timeout", int'(timeout), 0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
